// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and defaults for the pipeline hazard controller and its helpers.
package hazard_ctrl_unit_pkg;

    localparam int REG_SIZE  = 5;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_WAIT  = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    // Width of a down-counter that must hold values 0..cyc.
    function automatic int lu_cnt_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / data-memory-busy / taken-branch hazard controller for the 5-stage core,
// with a saturating stalled-cycle performance counter.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_W        = REG_SIZE,
    parameter int LU_STALL_CYC = 1,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ID_rs1_i,
    input  logic [REG_W-1:0] ID_rs2_i,
    input  logic             ID_rs1_used_i,
    input  logic             ID_rs2_used_i,
    input  logic [REG_W-1:0] EX_rd_i,
    input  logic             MemRead_i,
    input  logic             Branch_taken_i,
    input  logic             DMem_busy_i,
    output logic             PCWrite_o,
    output logic             Stall_o,
    output logic             NoOp_o,
    output logic             Flush_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int              LU_W      = lu_cnt_width(LU_STALL_CYC);
    localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LU_STALL_CYC - 1);
    localparam logic [LU_W-1:0] LU_LAST   = LU_W'(1);

    hz_state_e       state_reg, state_next;
    hz_state_e       ret_reg, ret_next;
    hz_state_e       eff_state;
    logic [LU_W-1:0] lu_cnt_reg, lu_cnt_next;

    logic rs1_hit;
    logic rs2_hit;
    logic hz;

    // An x0 destination never creates a dependency.
    assign rs1_hit = ID_rs1_used_i && (ID_rs1_i == EX_rd_i);
    assign rs2_hit = ID_rs2_used_i && (ID_rs2_i == EX_rd_i);
    assign hz      = MemRead_i && (EX_rd_i != '0) && (rs1_hit || rs2_hit);

    // Once memory releases, MEM_WAIT acts as the state it interrupted in the same cycle.
    assign eff_state = (state_reg == HZ_MEM_WAIT) ? ret_reg : state_reg;

    always_comb begin
        state_next  = state_reg;
        ret_next    = ret_reg;
        lu_cnt_next = lu_cnt_reg;
        PCWrite_o   = 1'b0;
        Stall_o     = 1'b0;
        NoOp_o      = 1'b0;
        Flush_o     = 1'b0;
        Freeze_o    = 1'b0;

        if (rst_i) begin
            state_next  = HZ_RUN;
            ret_next    = HZ_RUN;
            lu_cnt_next = '0;
        end else if (DMem_busy_i) begin
            Stall_o    = 1'b1;
            Freeze_o   = 1'b1;
            state_next = HZ_MEM_WAIT;
            ret_next   = eff_state;
        end else begin
            case (eff_state)
                HZ_LU_WAIT: begin
                    Stall_o     = 1'b1;
                    NoOp_o      = 1'b1;
                    lu_cnt_next = lu_cnt_reg - LU_W'(1);
                    state_next  = (lu_cnt_reg == LU_LAST) ? HZ_RUN : HZ_LU_WAIT;
                end
                default: begin
                    if (hz) begin
                        // Branch outcome is ignored: its operand is still in flight.
                        Stall_o = 1'b1;
                        NoOp_o  = 1'b1;
                        if (LU_STALL_CYC > 1) begin
                            lu_cnt_next = LU_RELOAD;
                            state_next  = HZ_LU_WAIT;
                        end else begin
                            state_next  = HZ_RUN;
                        end
                    end else begin
                        PCWrite_o  = 1'b1;
                        Flush_o    = Branch_taken_i;
                        state_next = HZ_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= HZ_RUN;
            ret_reg    <= HZ_RUN;
            lu_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ret_reg    <= ret_next;
            lu_cnt_reg <= lu_cnt_next;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk_i),
        .srst (rst_i),
        .en   (~PCWrite_o),
        .count(stall_cnt_o)
    );

endmodule
